// File: rtl/fp_mul_pkg.sv
// Shared constants and FSM encoding for the iterative single-precision multiplier.
// Imported by fp_mul; the shift-add core is generic and needs none of it.
package fp_mul_pkg;
    localparam int          FP_EXP_W   = 8;
    localparam int          FP_MAN_W   = 23;
    localparam int          FP_BIAS    = 127;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_INF_EXP = 8'hFF;
    localparam logic [4:0]  MUL_LAST   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_NORM = 2'd2,
        ST_RND  = 2'd3
    } state_t;
endpackage

// File: rtl/mul_shiftadd.sv
// Unsigned radix-2 shift-add multiplier: one multiplier bit is consumed per enabled cycle.
// load clears the accumulator and captures both operands.
module mul_shiftadd #(
    parameter int DATA_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   product
);
    logic [2*DATA_W-1:0] a_sh_r;
    logic [2*DATA_W-1:0] acc_r;
    logic [DATA_W-1:0]   b_r;

    // Accumulate a<<i whenever bit i of b is set; b shifts right so bit i reaches b_r[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r <= '0;
            b_r    <= '0;
            acc_r  <= '0;
        end else if (load) begin
            a_sh_r <= {{DATA_W{1'b0}}, a};
            b_r    <= b;
            acc_r  <= '0;
        end else if (en) begin
            if (b_r[0]) begin
                acc_r <= acc_r + a_sh_r;
            end
            a_sh_r <= {a_sh_r[2*DATA_W-2:0], 1'b0};
            b_r    <= {1'b0, b_r[DATA_W-1:1]};
        end
    end

    assign product = acc_r;
endmodule

// File: rtl/fp_mul.sv
// Iterative IEEE-754 single-precision multiplier, round-to-nearest-even, denormals flushed.
// start latches operands; done rises 27 edges later with res and flags.
import fp_mul_pkg::*;

module fp_mul #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              overflow,
    output logic              underflow,
    output logic              exception,
    output logic [DATA_W-1:0] res
);
    localparam logic signed [9:0] BIAS_E = 10'(2**(EXP_W-1)-1);

    state_t             state_r;
    logic [4:0]         cnt_r;
    logic               ld_r, sign_r, byp_r, byp_exc_r;
    logic [31:0]        byp_res_r;
    logic signed [9:0]  e_r;
    logic [23:0]        ma_r, mb_r, man_r;
    logic               guard_r, sticky_r;
    logic               done_r, ovf_r, unf_r, exc_r;
    logic [31:0]        res_r;
    logic [47:0]        prod_s;

    logic [7:0]         ea_s, eb_s;
    logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s, sign_s;
    logic               byp_s, byp_exc_s;
    logic [31:0]        byp_res_s;
    logic signed [9:0]  e_s;

    assign ea_s     = op_a[30:23];
    assign eb_s     = op_b[30:23];
    assign sign_s   = op_a[31] ^ op_b[31];
    assign a_zero_s = (ea_s == 8'd0);
    assign b_zero_s = (eb_s == 8'd0);
    assign a_inf_s  = (ea_s == FP_INF_EXP) && (op_a[FP_MAN_W-1:0] == 23'd0);
    assign b_inf_s  = (eb_s == FP_INF_EXP) && (op_b[FP_MAN_W-1:0] == 23'd0);
    assign a_nan_s  = (ea_s == FP_INF_EXP) && (op_a[FP_MAN_W-1:0] != 23'd0);
    assign b_nan_s  = (eb_s == FP_INF_EXP) && (op_b[FP_MAN_W-1:0] != 23'd0);
    assign e_s      = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_E;

    // Special and zero operands skip the arithmetic; their result is known at start.
    always_comb begin
        byp_s     = 1'b0;
        byp_exc_s = 1'b0;
        byp_res_s = 32'd0;
        if (a_nan_s || b_nan_s) begin
            byp_s     = 1'b1;
            byp_exc_s = 1'b1;
            byp_res_s = FP_QNAN;
        end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            byp_s     = 1'b1;
            byp_exc_s = 1'b1;
            byp_res_s = FP_QNAN;
        end else if (a_inf_s || b_inf_s) begin
            byp_s     = 1'b1;
            byp_exc_s = 1'b1;
            byp_res_s = {sign_s, FP_INF_EXP, 23'd0};
        end else if (a_zero_s || b_zero_s) begin
            byp_s     = 1'b1;
            byp_exc_s = 1'b0;
            byp_res_s = {sign_s, 31'd0};
        end else begin
            byp_s     = 1'b0;
            byp_exc_s = 1'b0;
            byp_res_s = 32'd0;
        end
    end

    logic               inc_s;
    logic [24:0]        sum_s;
    logic signed [9:0]  ef_s;
    logic [31:0]        rnd_res_s;
    logic               rnd_ovf_s, rnd_unf_s;
    logic               unused_s;

    // Round-to-nearest-even; a carry out of the mantissa leaves frac zero and bumps the exponent.
    always_comb begin
        inc_s     = guard_r & (sticky_r | man_r[0]);
        sum_s     = {1'b0, man_r} + {24'd0, inc_s};
        ef_s      = sum_s[24] ? (e_r + 10'sd1) : e_r;
        rnd_res_s = 32'd0;
        rnd_ovf_s = 1'b0;
        rnd_unf_s = 1'b0;
        if (byp_r) begin
            rnd_res_s = byp_res_r;
        end else if (ef_s >= 10'sd255) begin
            rnd_res_s = {sign_r, FP_INF_EXP, 23'd0};
            rnd_ovf_s = 1'b1;
        end else if (ef_s <= 10'sd0) begin
            rnd_res_s = {sign_r, 31'd0};
            rnd_unf_s = 1'b1;
        end else begin
            rnd_res_s = {sign_r, ef_s[7:0], sum_s[22:0]};
        end
    end

    assign unused_s = sum_s[23];

    mul_shiftadd #(.DATA_W(24)) u_core (
        .clk     (clk),
        .rst     (rst),
        .en      ((state_r == ST_MUL) && !ld_r),
        .load    ((state_r == ST_MUL) && ld_r),
        .a       (ma_r),
        .b       (mb_r),
        .product (prod_s)
    );

    // Control FSM: a start in any state restarts; the first MUL cycle loads the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 5'd0;
            ld_r      <= 1'b0;
            sign_r    <= 1'b0;
            byp_r     <= 1'b0;
            byp_exc_r <= 1'b0;
            byp_res_r <= 32'd0;
            e_r       <= 10'sd0;
            ma_r      <= 24'd0;
            mb_r      <= 24'd0;
            man_r     <= 24'd0;
            guard_r   <= 1'b0;
            sticky_r  <= 1'b0;
            done_r    <= 1'b1;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            exc_r     <= 1'b0;
            res_r     <= 32'd0;
        end else if (start) begin
            state_r   <= ST_MUL;
            cnt_r     <= 5'd0;
            ld_r      <= 1'b1;
            sign_r    <= sign_s;
            byp_r     <= byp_s;
            byp_exc_r <= byp_exc_s;
            byp_res_r <= byp_res_s;
            e_r       <= e_s;
            ma_r      <= a_zero_s ? 24'd0 : {1'b1, op_a[22:0]};
            mb_r      <= b_zero_s ? 24'd0 : {1'b1, op_b[22:0]};
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            exc_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_MUL: begin
                    if (ld_r) begin
                        ld_r   <= 1'b0;
                        done_r <= 1'b0;
                    end else if (cnt_r == MUL_LAST) begin
                        state_r <= ST_NORM;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                ST_NORM: begin
                    if (prod_s[47]) begin
                        man_r    <= prod_s[47:24];
                        guard_r  <= prod_s[23];
                        sticky_r <= |prod_s[22:0];
                        e_r      <= e_r + 10'sd1;
                    end else begin
                        man_r    <= prod_s[46:23];
                        guard_r  <= prod_s[22];
                        sticky_r <= |prod_s[21:0];
                    end
                    state_r <= ST_RND;
                end
                ST_RND: begin
                    res_r   <= rnd_res_s;
                    ovf_r   <= rnd_ovf_s;
                    unf_r   <= rnd_unf_s;
                    exc_r   <= byp_r & byp_exc_r;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign done      = done_r;
    assign overflow  = ovf_r;
    assign underflow = unf_r;
    assign exception = exc_r;
    assign res       = res_r;
endmodule

// File: tb/tb_fp_mul.sv
// Directed self-checking bench for fp_mul: results, flags, latency, abort and reset.
module tb_fp_mul;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        done, overflow, underflow, exception;
    logic [31:0] res;
    int          errors = 0;
    int          checks = 0;

    fp_mul dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .op_a(op_a), .op_b(op_b), .overflow(overflow),
        .underflow(underflow), .exception(exception), .res(res)
    );

    always #5 clk = ~clk;

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges after the start edge until done is seen high; -1 when the budget runs out.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL reset_done: got %b expected 1", done); end
        checks++;
        if (res !== 32'd0) begin errors++; $display("FAIL reset_res: got %h expected 00000000", res); end
        checks++;
        if ({overflow, underflow, exception} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {overflow, underflow, exception});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        pulse_start(32'h4000_0000, 32'h4040_0000);
        wait_done(cyc);
        checks++;
        if (cyc !== 27) begin errors++; $display("FAIL basic_latency: got %0d expected 27", cyc); end
        checks++;
        if (res !== 32'h40C0_0000) begin errors++; $display("FAIL basic_res: got %h expected 40c00000", res); end
        checks++;
        if ({overflow, underflow, exception} !== 3'b000) begin
            errors++; $display("FAIL basic_flags: got %b expected 000", {overflow, underflow, exception});
        end
    endtask

    // Flags are {overflow, underflow, exception}.
    task automatic test_vectors;
        logic [31:0] va [9] = '{32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0001, 32'h7F00_0000,
                                32'h0080_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h8000_0000};
        logic [31:0] vb [9] = '{32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0001, 32'h4000_0000,
                                32'h3F00_0000, 32'h3F80_0000, 32'h0000_0000, 32'h4000_0000,
                                32'h40A0_0000};
        logic [31:0] vr [9] = '{32'h4010_0000, 32'h3F80_0002, 32'h4010_0002, 32'h7F80_0000,
                                32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000,
                                32'h8000_0000};
        logic [2:0]  vf [9] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b000};
        int cyc;
        for (int i = 0; i < 9; i++) begin
            pulse_start(va[i], vb[i]);
            wait_done(cyc);
            checks++;
            if (cyc !== 27) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 27", i, cyc); end
            checks++;
            if (res !== vr[i]) begin errors++; $display("FAIL vec%0d_res: got %h expected %h", i, res, vr[i]); end
            checks++;
            if ({overflow, underflow, exception} !== vf[i]) begin
                errors++;
                $display("FAIL vec%0d_flags: got %b expected %b", i, {overflow, underflow, exception}, vf[i]);
            end
        end
    endtask

    task automatic test_abort;
        int cyc;
        pulse_start(32'h3F80_0000, 32'h4040_0000);
        repeat (9) @(posedge clk);
        pulse_start(32'h4000_0000, 32'h4000_0000);
        checks++;
        if (res !== 32'h8000_0000) begin errors++; $display("FAIL abort_hold: got %h expected 80000000", res); end
        wait_done(cyc);
        checks++;
        if (cyc !== 27) begin errors++; $display("FAIL abort_latency: got %0d expected 27", cyc); end
        checks++;
        if (res !== 32'h4080_0000) begin errors++; $display("FAIL abort_res: got %h expected 40800000", res); end
    endtask

    task automatic test_flag_clear;
        int cyc;
        pulse_start(32'h7F00_0000, 32'h4000_0000);
        wait_done(cyc);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        pulse_start(32'h3FC0_0000, 32'h4000_0000);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        checks++;
        if (res !== 32'h7F80_0000) begin errors++; $display("FAIL res_hold: got %h expected 7f800000", res); end
        wait_done(cyc);
        checks++;
        if (res !== 32'h4040_0000) begin errors++; $display("FAIL after_clear_res: got %h expected 40400000", res); end
    endtask

    task automatic test_reset_mid_op;
        int cyc;
        pulse_start(32'h4000_0000, 32'h4000_0000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b expected 1", done); end
        checks++;
        if (res !== 32'd0) begin errors++; $display("FAIL midrst_res: got %h expected 00000000", res); end
        checks++;
        if ({overflow, underflow, exception} !== 3'b000) begin
            errors++; $display("FAIL midrst_flags: got %b expected 000", {overflow, underflow, exception});
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_start(32'h3FC0_0000, 32'h3FC0_0000);
        wait_done(cyc);
        checks++;
        if (cyc !== 27) begin errors++; $display("FAIL postrst_latency: got %0d expected 27", cyc); end
        checks++;
        if (res !== 32'h4010_0000) begin errors++; $display("FAIL postrst_res: got %h expected 40100000", res); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_abort();
        test_flag_clear();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
